// File: rtl/microseq_slice.sv
// microseq_slice -- microprogram next-address sequencer.
//
// Holds the microPC, an auxiliary address register (ar) and a LIFO
// return-address stack of DEPTH entries. It produces the next microaddress
// combinationally from one of pc / ar / stack top / din, ORed with orin,
// and gated by zero_n.
//
// Parameters:
//   WIDTH  microaddress width (>=4)
//   DEPTH  return-stack entries (>=2)
//
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset
//   din          direct branch address
//   rin          auxiliary register load value
//   orin         OR-mask applied to the selected address
//   sel          source: 00 pc, 01 ar, 10 stack top, 11 din
//   zero_n       0 forces yout to zero
//   cin          microPC increment enable
//   re_n         0 loads ar from rin
//   fe_n         0 enables a stack operation
//   pup          with fe_n=0: 1 push, 0 pop
//   yout         next microaddress (combinational)
//   cout         cin & (yout all ones)
//   stack_full   count == DEPTH
//   stack_empty  count == 0
//   stack_err    sticky overflow/underflow flag
//
// Build option: define MICROSEQ_STACK_GUARD_EN to drop pushes when the stack
// is full and pops when it is empty, and to set the sticky stack_err flag
// when that happens. Without it the stack is circular and stack_err is 0.
module microseq_slice #(
   parameter int unsigned WIDTH = 12,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] din,
   input  logic [WIDTH-1:0] rin,
   input  logic [WIDTH-1:0] orin,
   input  logic [1:0]       sel,
   input  logic             zero_n,
   input  logic             cin,
   input  logic             re_n,
   input  logic             fe_n,
   input  logic             pup,
   output logic [WIDTH-1:0] yout,
   output logic             cout,
   output logic             stack_full,
   output logic             stack_empty,
   output logic             stack_err
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [WIDTH-1:0] pc;
   logic [WIDTH-1:0] ar;
   logic [WIDTH-1:0] stack [DEPTH];
   logic [CW-1:0]    count;
   // sp is the next write slot; it wraps modulo DEPTH independently of count
   // so the circular build can keep overwriting the oldest entry.
   logic [PW-1:0]    sp;
   logic [PW-1:0]    sp_inc;
   logic [PW-1:0]    sp_dec;
   logic [WIDTH-1:0] top;
   logic [WIDTH-1:0] mux;
   logic             push;
   logic             pop;

   assign push = ~fe_n & pup;
   assign pop  = ~fe_n & ~pup;

   always_comb begin
      sp_inc = (sp == LAST) ? '0 : sp + PW'(1);
      sp_dec = (sp == '0) ? LAST : sp - PW'(1);
   end

   // A push in the same cycle looks ahead: the top is the value being pushed.
   always_comb begin
      top = '0;
      if (push)
         top = pc;
      else if (count != '0)
         top = stack[sp_dec];
   end

   always_comb begin
      mux = pc;
      case (sel)
         2'b00: mux = pc;
         2'b01: mux = ar;
         2'b10: mux = top;
         2'b11: mux = din;
         default: mux = pc;
      endcase
   end

   always_comb begin
      yout = '0;
      if (reset_n && zero_n)
         yout = mux | orin;
      cout = reset_n & cin & (&yout);
   end

   assign stack_full  = (count == FULL);
   assign stack_empty = (count == '0);

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         pc    <= '0;
         ar    <= '0;
         count <= '0;
         sp    <= '0;
         for (int unsigned i = 0; i < DEPTH; i++)
            stack[i] <= '0;
      end else begin
         pc <= yout + WIDTH'(cin);
         if (!re_n)
            ar <= rin;
`ifdef MICROSEQ_STACK_GUARD_EN
         if (push) begin
            if (count != FULL) begin
               stack[sp] <= pc;
               sp        <= sp_inc;
               count     <= count + CW'(1);
            end
         end else if (pop) begin
            if (count != '0) begin
               sp    <= sp_dec;
               count <= count - CW'(1);
            end
         end
`else
         if (push) begin
            stack[sp] <= pc;
            sp        <= sp_inc;
            if (count != FULL)
               count <= count + CW'(1);
         end else if (pop) begin
            sp <= sp_dec;
            if (count != '0)
               count <= count - CW'(1);
         end
`endif
      end
   end

`ifdef MICROSEQ_STACK_GUARD_EN
   logic err;

   always_ff @(posedge clock) begin
      if (!reset_n)
         err <= 1'b0;
      else if ((push && count == FULL) || (pop && count == '0))
         err <= 1'b1;
   end

   assign stack_err = err;
`else
   assign stack_err = 1'b0;
`endif

endmodule

// File: doc/microseq_slice.md
Name: microseq_slice

Overview:
- Parametrised microprogram next-address sequencer, successor to the 4-bit sequencer slice.
- One instance covers the full microaddress width, so cascading slices is no longer required.
- Holds the microPC, an auxiliary address register and a LIFO return-address stack of configurable depth.
- Adds synchronous reset, occupancy flags and guarded push/pop. It sits between the microinstruction pipeline register and the control-store address input.

Parameters:
- WIDTH, 12, microaddress width in bits (>=4).
- DEPTH, 4, return-stack entries (>=2). Occupancy counter width is $clog2(DEPTH+1).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous reset, active-low.
- din  input  WIDTH  direct branch address.
- rin  input  WIDTH  auxiliary register load value.
- orin  input  WIDTH  OR-mask applied to the selected address.
- sel  input  2  source select: 00 pc, 01 ar, 10 stack top, 11 din.
- zero_n  input  1  0 forces yout to all zeros.
- cin  input  1  microPC increment enable.
- re_n  input  1  0 loads ar from rin.
- fe_n  input  1  0 enables a stack operation this cycle.
- pup  input  1  with fe_n=0: 1 = push, 0 = pop.
- yout  output  WIDTH  next microaddress (combinational).
- cout  output  1  carry out, = cin & (&yout).
- stack_full  output  1  count == DEPTH.
- stack_empty  output  1  count == 0.
- stack_err  output  1  sticky overflow/underflow flag (guard build only).

Behaviour:
- **Decision:** one clock; reset is synchronous and active-low. Ports are clock and reset_n.
- **Reset (reset_n=0 at rising edge):**
  - pc=0, ar=0, count=0, all stack entries 0, stack_err=0.
  - While reset_n=0, yout=0 and cout=0, regardless of other inputs.
- **Mux and output:**
  - Source selected by sel: pc, ar, top or din.
  - top = stack[count-1] normally.
  - Lookahead: if fe_n=0 and pup=1 in the same cycle, top = pc, i.e. the value being pushed.
  - Empty stack with no push: top = 0.
  - yout = zero_n ? (mux | orin) : 0.
  - cout = cin & (yout == all ones).
- **Clocked updates (reset_n=1):**
  - pc <= yout + cin, truncated to WIDTH. All-ones + 1 wraps to 0 and asserts cout that cycle.
  - re_n=0: ar <= rin. This is independent of the stack and of pc.
  - Push (fe_n=0, pup=1): stack[count] <= pc, the pre-update pc; count <= count+1.
  - Pop (fe_n=0, pup=0): count <= count-1. The popped value is visible on yout in the same cycle when sel=10.
  - fe_n=1: stack and count unchanged.
  - pc, ar and the stack update concurrently in one edge.
  - A push plus sel=10 in the same cycle yields yout=pc|orin and pushes pc.
- **Latency:** yout is zero-cycle combinational. Registers are visible one cycle after the edge.
- **Boundaries:** see Optional Feature.
- stack_full and stack_empty derive purely from count, with no registered delay.

Optional Feature:
- Macro: MICROSEQ_STACK_GUARD_EN.
- **Defined:**
  - Push when full is dropped: no write, count holds, stack_err <= 1.
  - Pop when empty is dropped: count holds at 0, stack_err <= 1.
  - stack_err stays set until reset.
- **Undefined:**
  - The stack is circular: push when full overwrites the oldest entry and count saturates at DEPTH.
  - The internal pointer wraps modulo DEPTH.
  - Pop when empty leaves count at 0 and the pointer still decrements modulo DEPTH.
  - stack_err is tied 0.

Test Plan:
- **Reset sequencing:** reset_n=0 one cycle, then reset_n=1, sel=00, cin=1, zero_n=1, orin=0 for 5 cycles -> yout 0,1,2,3,4; stack_empty=1; cout=0.
- **Call/return:** run pc to 0x010. Then sel=11, din=0x200, fe_n=0, pup=1 -> yout=0x200, stack_full=0. Then sel=00 for 3 cycles, then sel=10, fe_n=0, pup=0 -> yout=0x010, next pc=0x011, stack_empty=1.
- **Lookahead and OR/zero:** pc=0x0A0, sel=10, fe_n=0, pup=1, orin=0x005 -> yout=0x0A5. Next cycle zero_n=0 -> yout=0, next pc=cin.
- **Wrap and cout:** sel=11, din=0xFFF, cin=1 -> cout=1, next pc=0x000. Same with cin=0 -> cout=0, next pc=0xFFF.
- **Full/empty guard (guard build):**
  - 5 pushes of pc values 1..5 -> stack_full after the 4th, the 5th is dropped, stack_err=1.
  - 4 pops with sel=10 -> yout 4,3,2,1; a 5th pop -> yout=0, count stays 0.
  - Reset clears stack_err.
- **Circular build:** same 5 pushes then 4 pops -> yout 5,4,3,2; stack_err=0.
